mem_port_arbiter: RTL and testbench

- Shares the single external memory port (ADDR/BURST/REQ/WRB/WDATA/BSTROBE, RDATA/ACK/STALL) between the I-cache interface router and the D-cache interface router.
- Grants the port to one requester at a time and holds the grant for the whole transaction: BURST_LENGTH beats for INCR, 1 beat for single.
- Round-robin between requesters; freeze-aware like the rest of the memory subsystem.

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the external memory port between the I-cache and
// D-cache routers; a grant is held until the owner's whole transaction has completed.
module mem_port_arbiter #(
    parameter int BURST_LENGTH = 8,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [1:0]        i_burst,
    input  logic              i_wrb,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [3:0]        i_bstrobe,
    output logic              i_ack,
    output logic              i_stall,
    output logic              i_gnt,

    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_burst,
    input  logic              d_wrb,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_bstrobe,
    output logic              d_ack,
    output logic              d_stall,
    output logic              d_gnt,

    output logic [DATA_W-1:0] rdata_o,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_burst,
    output logic              mem_req,
    output logic              mem_wrb,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_bstrobe,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic              mem_stall,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] LEN_INCR   = 4'(BURST_LENGTH);

    state_t     state_reg, state_next;
    logic       last_d_reg, last_d_next;
    logic [3:0] beat_cnt_reg, beat_cnt_next;
    logic [3:0] len_reg, len_next;

    logic own_i;
    logic own_d;
    logic beat_done;
    logic last_beat;

    assign own_i = (state_reg == GNT_I);
    assign own_d = (state_reg == GNT_D);

    assign i_gnt   = own_i;
    assign d_gnt   = own_d;
    assign busy    = own_i | own_d;
    assign rdata_o = mem_rdata;

    // Port routing follows the registered owner; the port is quiet in IDLE.
    always_comb begin
        mem_addr    = '0;
        mem_burst   = '0;
        mem_req     = 1'b0;
        mem_wrb     = 1'b0;
        mem_wdata   = '0;
        mem_bstrobe = '0;
        if (own_i) begin
            mem_addr    = i_addr;
            mem_burst   = i_burst;
            mem_req     = i_req;
            mem_wrb     = i_wrb;
            mem_wdata   = i_wdata;
            mem_bstrobe = i_bstrobe;
        end else if (own_d) begin
            mem_addr    = d_addr;
            mem_burst   = d_burst;
            mem_req     = d_req;
            mem_wrb     = d_wrb;
            mem_wdata   = d_wdata;
            mem_bstrobe = d_bstrobe;
        end
    end

    assign i_ack   = own_i & mem_ack;
    assign i_stall = own_i ? mem_stall : 1'b1;
    assign d_ack   = own_d & mem_ack;
    assign d_stall = own_d ? mem_stall : 1'b1;

    // An ack only counts while the owner is actually requesting and the port is not stalled.
    assign beat_done = busy & mem_req & mem_ack & ~mem_stall;
    assign last_beat = (beat_cnt_reg == (len_reg - 4'd1));

    always_comb begin
        state_next    = state_reg;
        last_d_next   = last_d_reg;
        beat_cnt_next = beat_cnt_reg;
        len_next      = len_reg;
        if (!freeze) begin
            case (state_reg)
                IDLE: begin
                    if (i_req && (!d_req || last_d_reg)) begin
                        state_next    = GNT_I;
                        last_d_next   = 1'b0;
                        beat_cnt_next = 4'd0;
                        len_next      = (i_burst == BURST_INCR) ? LEN_INCR : 4'd1;
                    end else if (d_req) begin
                        state_next    = GNT_D;
                        last_d_next   = 1'b1;
                        beat_cnt_next = 4'd0;
                        len_next      = (d_burst == BURST_INCR) ? LEN_INCR : 4'd1;
                    end
                end
                GNT_I, GNT_D: begin
                    if (beat_done) begin
                        if (last_beat) begin
                            state_next    = IDLE;
                            beat_cnt_next = 4'd0;
                        end else begin
                            beat_cnt_next = beat_cnt_reg + 4'd1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // last_d resets high so the I side wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            last_d_reg   <= 1'b1;
            beat_cnt_reg <= 4'd0;
            len_reg      <= 4'd0;
        end else begin
            state_reg    <= state_next;
            last_d_reg   <= last_d_next;
            beat_cnt_reg <= beat_cnt_next;
            len_reg      <= len_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: hand vectors, directed burst sequences and random
// traffic, all checked against a transaction-level owner/beats-left model.
module tb_mem_port_arbiter;

    localparam int BL = 8;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset, freeze;
    logic          i_req, i_wrb, d_req, d_wrb;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [1:0]    i_burst, d_burst, mem_burst;
    logic [DW-1:0] i_wdata, d_wdata, mem_wdata, mem_rdata, rdata_o;
    logic [3:0]    i_bstrobe, d_bstrobe, mem_bstrobe;
    logic          i_ack, i_stall, i_gnt, d_ack, d_stall, d_gnt;
    logic          mem_req, mem_wrb, mem_ack, mem_stall, busy;

    mem_port_arbiter #(.BURST_LENGTH(BL), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .i_req(i_req), .i_addr(i_addr), .i_burst(i_burst), .i_wrb(i_wrb),
        .i_wdata(i_wdata), .i_bstrobe(i_bstrobe),
        .i_ack(i_ack), .i_stall(i_stall), .i_gnt(i_gnt),
        .d_req(d_req), .d_addr(d_addr), .d_burst(d_burst), .d_wrb(d_wrb),
        .d_wdata(d_wdata), .d_bstrobe(d_bstrobe),
        .d_ack(d_ack), .d_stall(d_stall), .d_gnt(d_gnt),
        .rdata_o(rdata_o),
        .mem_addr(mem_addr), .mem_burst(mem_burst), .mem_req(mem_req), .mem_wrb(mem_wrb),
        .mem_wdata(mem_wdata), .mem_bstrobe(mem_bstrobe), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .mem_stall(mem_stall),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the port, how many beats remain, who won last.
    int m_owner;   // 0 none, 1 I, 2 D
    int m_left;
    bit m_last_d;

    typedef struct {
        bit       rst, frz, ireq, dreq, ack, stall;
        bit [7:0] exp;
    } vec_t;
    vec_t tbl[15];

    function automatic vec_t mk(bit rst, bit frz, bit ireq, bit dreq, bit ack, bit stall,
                                bit [7:0] exp);
        vec_t v;
        v.rst = rst; v.frz = frz; v.ireq = ireq; v.dreq = dreq;
        v.ack = ack; v.stall = stall; v.exp = exp;
        return v;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ctrl_vec();
        return {i_gnt, d_gnt, busy, mem_req, i_ack, i_stall, d_ack, d_stall};
    endfunction

    function automatic logic [127:0] route_vec();
        return {57'd0, mem_addr, mem_burst, mem_wrb, mem_wdata, mem_bstrobe};
    endfunction

    function automatic bit model_req();
        return (m_owner == 1) ? i_req : (m_owner == 2) ? d_req : 1'b0;
    endfunction

    task automatic check_model();
        bit oi, od;
        logic [7:0]   ec;
        logic [127:0] ed;
        oi = (m_owner == 1);
        od = (m_owner == 2);
        ec = {oi, od, oi | od, model_req(), oi & mem_ack, oi ? mem_stall : 1'b1,
              od & mem_ack, od ? mem_stall : 1'b1};
        ed = '0;
        if (oi) ed = {57'd0, i_addr, i_burst, i_wrb, i_wdata, i_bstrobe};
        else if (od) ed = {57'd0, d_addr, d_burst, d_wrb, d_wdata, d_bstrobe};
        chk("ctrl", ctrl_vec(), ec);
        chk("route", route_vec(), ed);
        chk("rdata", rdata_o, mem_rdata);
    endtask

    task automatic update_model();
        bit req_now;
        req_now = model_req();
        if (reset) begin
            m_owner = 0; m_left = 0; m_last_d = 1'b1;
        end else if (!freeze) begin
            if (m_owner == 0) begin
                if (i_req && (!d_req || m_last_d)) begin
                    m_owner = 1; m_last_d = 1'b0; m_left = (i_burst == 2'b01) ? BL : 1;
                end else if (d_req) begin
                    m_owner = 2; m_last_d = 1'b1; m_left = (d_burst == 2'b01) ? BL : 1;
                end
            end else if (req_now && mem_ack && !mem_stall) begin
                m_left--;
                if (m_left == 0) m_owner = 0;
            end
        end
    endtask

    // Inputs are already driven just after a negedge; check, clock, advance model.
    task automatic cycle();
        #1;
        check_model();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic clr();
        reset = 0; freeze = 0;
        i_req = 0; i_addr = '0; i_burst = '0; i_wrb = 0; i_wdata = '0; i_bstrobe = '0;
        d_req = 0; d_addr = '0; d_burst = '0; d_wrb = 0; d_wdata = '0; d_bstrobe = '0;
        mem_rdata = '0; mem_ack = 0; mem_stall = 0;
    endtask

    // One requester runs a transaction with ack every cycle; stalls land on granted
    // cycles st_a/st_b and a 3-cycle freeze starts once frz_at beats are counted.
    task automatic burst(input bit is_d, input bit [1:0] b, input int st_a, input int st_b,
                         input int frz_at, output int beats);
        int gcyc, frz;
        bit done;
        gcyc = 0; frz = 0; beats = 0; done = 0;
        clr();
        mem_ack = 1;
        if (is_d) begin
            d_req = 1; d_burst = b; d_addr = 32'h0000_2000; d_wrb = 1;
            d_wdata = 32'hDEAD_BEEF; d_bstrobe = 4'b0011;
        end else begin
            i_req = 1; i_burst = b; i_addr = 32'h0000_1000; i_wdata = 32'h1234_5678;
            i_bstrobe = 4'hF;
        end
        for (int k = 0; k < 40 && !done; k++) begin
            freeze = 0; mem_stall = 0;
            if (m_owner != 0) begin
                gcyc++;
                mem_stall = (gcyc == st_a) || (gcyc == st_b);
                if (beats == frz_at && frz < 3) begin
                    freeze = 1; frz++;
                end
            end else if (gcyc > 0) begin
                i_req = 0; d_req = 0; done = 1;
            end
            mem_rdata = $urandom;
            #1;
            if (busy && mem_req && !freeze &&
                (is_d ? (d_ack && !d_stall) : (i_ack && !i_stall)))
                beats++;
            cycle();
        end
        if (!done) chk("burst_timeout", 128'd0, 128'd1);
        clr();
    endtask

    int  n;
    bit  prev_i, prev_d, done_c;
    byte winners[$];

    initial begin
        clr();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_owner = 0; m_left = 0; m_last_d = 1'b1;
        reset = 0;
        #1;
        chk("reset_ctrl", ctrl_vec(), 8'b0000_0101);
        chk("reset_route", route_vec(), 128'd0);
        chk("reset_rdata", rdata_o, 0);

        // {i_gnt,d_gnt,busy,mem_req,i_ack,i_stall,d_ack,d_stall}
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 8'b0000_0101);
        tbl[1]  = mk(0, 0, 0, 1, 0, 0, 8'b0000_0101);
        tbl[2]  = mk(0, 0, 0, 1, 0, 0, 8'b0111_0100);
        tbl[3]  = mk(0, 0, 0, 1, 1, 0, 8'b0111_0110);
        tbl[4]  = mk(0, 0, 1, 0, 0, 0, 8'b0000_0101);
        tbl[5]  = mk(0, 0, 1, 0, 1, 1, 8'b1011_1101);
        tbl[6]  = mk(0, 0, 0, 0, 1, 0, 8'b1010_1001);
        tbl[7]  = mk(0, 1, 1, 0, 1, 0, 8'b1011_1001);
        tbl[8]  = mk(0, 0, 1, 0, 1, 0, 8'b1011_1001);
        tbl[9]  = mk(0, 0, 1, 1, 0, 0, 8'b0000_0101);
        tbl[10] = mk(0, 0, 1, 1, 0, 0, 8'b0111_0100);
        tbl[11] = mk(0, 0, 1, 1, 1, 0, 8'b0111_0110);
        tbl[12] = mk(0, 0, 1, 1, 0, 0, 8'b0000_0101);
        tbl[13] = mk(1, 0, 1, 1, 0, 0, 8'b1011_0001);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 8'b0000_0101);
        for (int r = 0; r < 15; r++) begin
            clr();
            reset = tbl[r].rst; freeze = tbl[r].frz;
            i_req = tbl[r].ireq; d_req = tbl[r].dreq; d_wrb = 1;
            mem_ack = tbl[r].ack; mem_stall = tbl[r].stall;
            #1;
            chk($sformatf("vec%0d", r), ctrl_vec(), tbl[r].exp);
            cycle();
        end

        burst(0, 2'b01, -1, -1, -1, n);
        chk("i_incr_beats", n, 8);
        burst(1, 2'b00, -1, -1, -1, n);
        chk("d_single_write_beats", n, 1);
        burst(0, 2'b01, 2, 5, -1, n);
        chk("stalled_incr_beats", n, 8);
        burst(1, 2'b01, -1, -1, 4, n);
        chk("frozen_incr_beats", n, 8);
        burst(0, 2'b10, -1, -1, -1, n);
        chk("burst10_single_beats", n, 1);

        // Contention from reset: expect I, D, I.
        clr(); reset = 1; cycle();
        clr(); mem_ack = 1; i_req = 1; d_req = 1; i_burst = 2'b01; d_burst = 2'b01;
        prev_i = 0; prev_d = 0; done_c = 0;
        for (int k = 0; k < 60 && !done_c; k++) begin
            if (winners.size() == 3) begin
                d_req = 0;
                if (m_owner == 0) begin
                    i_req = 0; done_c = 1;
                end
            end
            #1;
            if (i_gnt && !prev_i) winners.push_back(8'd1);
            if (d_gnt && !prev_d) winners.push_back(8'd2);
            prev_i = i_gnt; prev_d = d_gnt;
            cycle();
        end
        chk("contention_grants", winners.size(), 3);
        if (winners.size() >= 3) begin
            chk("contention_first", winners[0], 1);
            chk("contention_second", winners[1], 2);
            chk("contention_third", winners[2], 1);
        end

        // Reset in the middle of a D burst with an I request pending.
        clr(); d_req = 1; d_burst = 2'b01; mem_ack = 1;
        cycle();
        repeat (3) cycle();
        i_req = 1; reset = 1;
        cycle();
        reset = 0; d_req = 0;
        #1;
        chk("rst_mid_d_gnt", d_gnt, 0);
        chk("rst_mid_mem_req", mem_req, 0);
        chk("rst_mid_busy", busy, 0);
        cycle();
        #1;
        chk("rst_mid_i_gnt", i_gnt, 1);
        cycle();
        clr();
        cycle();

        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(99) == 0);
            freeze    = ($urandom_range(19) == 0);
            i_req     = ($urandom_range(9) < 6);
            d_req     = ($urandom_range(9) < 6);
            i_burst   = 2'($urandom_range(3));
            d_burst   = 2'($urandom_range(3));
            i_addr    = $urandom; d_addr = $urandom;
            i_wdata   = $urandom; d_wdata = $urandom;
            i_wrb     = 1'($urandom_range(1)); d_wrb = 1'($urandom_range(1));
            i_bstrobe = 4'($urandom_range(15)); d_bstrobe = 4'($urandom_range(15));
            mem_rdata = $urandom;
            mem_ack   = ($urandom_range(9) < 7);
            mem_stall = ($urandom_range(3) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
